regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 26 ++
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/grant bus between two writeback requesters and the
// regfile write-port arbiter, plus the registered regfile write port.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;
  logic        ctrl_writeEn;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        init_done;

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, ctrl_writeEn, ctrl_writeReg, data_writeReg, init_done
  );

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, ctrl_writeEn, ctrl_writeReg, data_writeReg, init_done
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin arbiter for a single regfile write port, with an
// optional post-reset sweep that zeroes registers 1..31.
//
// state  | meaning
// S_INIT | clear sweep in progress, one zero write per cycle, requesters stalled
// S_RUN  | arbitrate A/B writebacks, registered write port one cycle after transfer
module regfile_wb_arbiter #(
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  regfile_wb_arbiter_if.slave   bus
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        last_b_q, last_b_d;
  logic        we_q, we_d;
  logic [4:0]  wr_q, wr_d;
  logic [31:0] wd_q, wd_d;
  logic        done_q, done_d;
  logic        grant_a, grant_b;

  // Grants are gated by reset so no handshake can complete on a reset edge.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (ctrl_reset && (state_q == S_RUN)) begin
      if (bus.a_valid && bus.b_valid) begin
        grant_a = last_b_q;
        grant_b = ~last_b_q;
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    we_d     = 1'b0;
    wr_d     = wr_q;
    wd_d     = wd_q;
    done_d   = (state_q == S_RUN);
    if (state_q == S_INIT) begin
      we_d  = 1'b1;
      wr_d  = cnt_q;
      wd_d  = 32'd0;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) state_d = S_RUN;
    end else if (grant_a) begin
      we_d     = (bus.a_reg != 5'd0);
      wr_d     = bus.a_reg;
      wd_d     = bus.a_data;
      last_b_d = 1'b0;
    end else if (grant_b) begin
      we_d     = (bus.b_reg != 5'd0);
      wr_d     = bus.b_reg;
      wd_d     = bus.b_data;
      last_b_d = 1'b1;
    end
  end

  // last_b resets high so requester A wins the first tie.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      state_q  <= INIT_CLEAR ? S_INIT : S_RUN;
      cnt_q    <= 5'd1;
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      wr_q     <= 5'd0;
      wd_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      we_q     <= we_d;
      wr_q     <= wr_d;
      wd_q     <= wd_d;
      done_q   <= done_d;
    end
  end

  assign bus.a_ready       = grant_a;
  assign bus.b_ready       = grant_b;
  assign bus.ctrl_writeEn  = we_q;
  assign bus.ctrl_writeReg = wr_q;
  assign bus.data_writeReg = wd_q;
  assign bus.init_done     = done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: instance 0 without clear sweep, instance 1 with it,
// a behavioural model plus a regfile per instance, directed cases then random traffic.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [2];
  logic        av [2], bv [2];
  logic [4:0]  ar [2], br [2];
  logic [31:0] ad [2], bd [2];
  logic        o_ar [2], o_br [2], o_we [2], o_done [2];
  logic [4:0]  o_wr [2];
  logic [31:0] o_wd [2];

  regfile_wb_arbiter_if bus0();
  regfile_wb_arbiter_if bus1();

  assign bus0.a_valid = av[0];  assign bus0.a_reg = ar[0];  assign bus0.a_data = ad[0];
  assign bus0.b_valid = bv[0];  assign bus0.b_reg = br[0];  assign bus0.b_data = bd[0];
  assign bus1.a_valid = av[1];  assign bus1.a_reg = ar[1];  assign bus1.a_data = ad[1];
  assign bus1.b_valid = bv[1];  assign bus1.b_reg = br[1];  assign bus1.b_data = bd[1];
  assign o_ar[0] = bus0.a_ready;  assign o_br[0] = bus0.b_ready;
  assign o_we[0] = bus0.ctrl_writeEn;  assign o_wr[0] = bus0.ctrl_writeReg;
  assign o_wd[0] = bus0.data_writeReg;  assign o_done[0] = bus0.init_done;
  assign o_ar[1] = bus1.a_ready;  assign o_br[1] = bus1.b_ready;
  assign o_we[1] = bus1.ctrl_writeEn;  assign o_wr[1] = bus1.ctrl_writeReg;
  assign o_wd[1] = bus1.data_writeReg;  assign o_done[1] = bus1.init_done;

  regfile_wb_arbiter #(.INIT_CLEAR(1'b0)) dut0 (.clock(clk), .ctrl_reset(rstn[0]), .bus(bus0));
  regfile_wb_arbiter #(.INIT_CLEAR(1'b1)) dut1 (.clock(clk), .ctrl_reset(rstn[1]), .bus(bus1));

  // Model: what the write port must show, derived from sweep progress and winner history.
  typedef struct {
    bit          sweeping;
    int          writes_issued;
    bit          b_won_last;
    bit          we;
    logic [4:0]  wr;
    logic [31:0] wd;
    bit          done;
  } mdl_t;

  mdl_t        m [2];
  bit          ok [2];
  bit          acc_a [2], acc_b [2];
  logic [31:0] rf [2][32];
  logic [31:0] ref_rf [2][32];
  logic [1:0]  gm, gc;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [1:0] winner(mdl_t mm, logic rn, logic va, logic vb);
    if (!rn || mm.sweeping) return 2'b00;
    if (va && vb) return mm.b_won_last ? 2'b10 : 2'b01;
    if (va) return 2'b10;
    if (vb) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got 0x%0h expected 0x%0h", nm, k, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!ok[k]) begin
        for (int i = 0; i < 32; i++) begin
          rf[k][i]     = (i == 0) ? 32'd0 : (32'hA5A5_0000 | 32'(i));
          ref_rf[k][i] = (i == 0) ? 32'd0 : (32'hA5A5_0000 | 32'(i));
        end
      end
      if (o_we[k] === 1'b1) rf[k][o_wr[k]] = o_wd[k];
      if (ok[k] && m[k].we) ref_rf[k][m[k].wr] = m[k].wd;
      gm = winner(m[k], rstn[k], av[k], bv[k]);
      acc_a[k] = gm[1];
      acc_b[k] = gm[0];
      if (!rstn[k]) begin
        m[k].sweeping      = (k == 1);
        m[k].writes_issued = 0;
        m[k].b_won_last    = 1'b1;
        m[k].we            = 1'b0;
        m[k].wr            = 5'd0;
        m[k].wd            = 32'd0;
        m[k].done          = 1'b0;
        ok[k]              = 1'b1;
      end else if (ok[k]) begin
        m[k].done = !m[k].sweeping;
        if (m[k].sweeping) begin
          m[k].writes_issued++;
          m[k].we = 1'b1;
          m[k].wr = 5'(m[k].writes_issued);
          m[k].wd = 32'd0;
          if (m[k].writes_issued == 31) m[k].sweeping = 1'b0;
        end else if (gm != 2'b00) begin
          m[k].wr = gm[1] ? ar[k] : br[k];
          m[k].wd = gm[1] ? ad[k] : bd[k];
          m[k].we = (m[k].wr != 5'd0);
          m[k].b_won_last = gm[0];
        end else begin
          m[k].we = 1'b0;
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #3;
    for (int k = 0; k < 2; k++) begin
      if (ok[k]) begin
        gc = winner(m[k], rstn[k], av[k], bv[k]);
        chk("a_ready", k, 32'(o_ar[k]), 32'(gc[1]));
        chk("b_ready", k, 32'(o_br[k]), 32'(gc[0]));
        chk("ready_exclusive", k, 32'(o_ar[k] & o_br[k]), 32'd0);
        chk("writeEn", k, 32'(o_we[k]), 32'(m[k].we));
        chk("writeReg", k, 32'(o_wr[k]), 32'(m[k].wr));
        chk("writeData", k, o_wd[k], m[k].wd);
        chk("init_done", k, 32'(o_done[k]), 32'(m[k].done));
      end
    end
  end

  task automatic sweep_check(input int k);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      #3;
      chk("sweep_we", k, 32'(o_we[k]), 32'd1);
      chk("sweep_reg", k, 32'(o_wr[k]), 32'(i));
      chk("sweep_data", k, o_wd[k], 32'd0);
      chk("sweep_done", k, 32'(o_done[k]), 32'd0);
      chk("sweep_a_ready", k, 32'(o_ar[k]), 32'(av[k] && (i == 31)));
    end
  endtask

  bit found;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0; av[k] = 1'b0; bv[k] = 1'b0;
      ar[k] = 5'd0; br[k] = 5'd0; ad[k] = 32'd0; bd[k] = 32'd0;
    end
    repeat (2) @(negedge clk);

    // No clear sweep: B is accepted in the very first cycle out of reset.
    rstn[0] = 1'b1; bv[0] = 1'b1; br[0] = 5'd9; bd[0] = 32'hFFFF_FFFF;
    #3 chk("noclear_b_ready", 0, 32'(o_br[0]), 32'd1);
    @(negedge clk); bv[0] = 1'b0;
    #3;
    chk("noclear_done", 0, 32'(o_done[0]), 32'd1);
    chk("noclear_reg", 0, 32'(o_wr[0]), 32'd9);
    @(negedge clk);
    #3 chk("noclear_readback", 0, rf[0][9], 32'hFFFF_FFFF);

    // Clear sweep with A pending throughout.
    @(negedge clk);
    rstn[1] = 1'b1; av[1] = 1'b1; ar[1] = 5'd5; ad[1] = 32'h55;
    #3 chk("init_a_stalled", 1, 32'(o_ar[1]), 32'd0);
    sweep_check(1);
    @(negedge clk);
    #3;
    chk("post_sweep_done", 1, 32'(o_done[1]), 32'd1);
    chk("first_a_reg", 1, 32'(o_wr[1]), 32'd5);
    chk("first_a_data", 1, o_wd[1], 32'h55);
    for (int i = 1; i < 32; i++) chk("cleared_reg", 1, rf[1][i], 32'd0);

    // One B transfer so the next tie goes to A, then alternation.
    @(negedge clk);
    av[1] = 1'b0; bv[1] = 1'b1; br[1] = 5'd4; bd[1] = 32'h22;
    #3 chk("solo_b_ready", 1, 32'(o_br[1]), 32'd1);
    @(negedge clk);
    av[1] = 1'b1; ar[1] = 5'd3; ad[1] = 32'h11;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      #3;
      chk("alt_a_ready", 1, 32'(o_ar[1]), 32'((i % 2) == 0));
      chk("alt_b_ready", 1, 32'(o_br[1]), 32'((i % 2) == 1));
      chk("alt_reg", 1, 32'(o_wr[1]), ((i % 2) == 0) ? 32'd4 : 32'd3);
    end

    // Destination register 0: handshake completes, no write.
    @(negedge clk); av[1] = 1'b0;
    #3 chk("pend_b_ready", 1, 32'(o_br[1]), 32'd1);
    @(negedge clk); br[1] = 5'd0; bd[1] = 32'hDEAD_BEEF;
    #3 chk("r0_b_ready", 1, 32'(o_br[1]), 32'd1);
    @(negedge clk); bv[1] = 1'b0;
    #3;
    chk("r0_no_write", 1, 32'(o_we[1]), 32'd0);
    chk("r0_readback", 1, rf[1][0], 32'd0);

    // Write issued just before reset is still presented.
    @(negedge clk); av[1] = 1'b1; ar[1] = 5'd7; ad[1] = 32'd5;
    #3 chk("pre_reset_a_ready", 1, 32'(o_ar[1]), 32'd1);
    @(negedge clk); av[1] = 1'b0; rstn[1] = 1'b0;
    #3;
    chk("pre_reset_we", 1, 32'(o_we[1]), 32'd1);
    chk("pre_reset_reg", 1, 32'(o_wr[1]), 32'd7);
    @(negedge clk);
    #3;
    chk("reset_we", 1, 32'(o_we[1]), 32'd0);
    chk("reset_data", 1, o_wd[1], 32'd0);
    chk("reset_readback7", 1, rf[1][7], 32'd5);

    // Reset in mid-sweep restarts from register 1.
    @(negedge clk); rstn[1] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      #3;
      if (o_we[1] === 1'b1 && o_wr[1] === 5'd15) found = 1'b1;
    end
    chk("mid_sweep_reached", 1, 32'(found), 32'd1);
    @(negedge clk); rstn[1] = 1'b0;
    @(negedge clk); rstn[1] = 1'b1;
    #3 chk("restart_idle", 1, 32'(o_we[1]), 32'd0);
    sweep_check(1);
    @(negedge clk);
    #3 chk("restart_done", 1, 32'(o_done[1]), 32'd1);

    // Random traffic honouring the hold-while-not-accepted rule.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        rstn[k] = ($urandom_range(0, 249) != 0);
        if (!(av[k] && !acc_a[k])) begin
          av[k] = ($urandom_range(0, 9) < 6);
          ar[k] = 5'($urandom_range(0, 31));
          ad[k] = $urandom;
        end
        if (!(bv[k] && !acc_b[k])) begin
          bv[k] = ($urandom_range(0, 9) < 6);
          br[k] = 5'($urandom_range(0, 31));
          bd[k] = $urandom;
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b1; av[k] = 1'b0; bv[k] = 1'b0;
    end
    repeat (40) @(negedge clk);
    #3;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) chk("final_regfile", k, rf[k][i], ref_rf[k][i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
